secuenciador_registros: RTL
===========================

Name: secuenciador_registros

Overview:
Controller that sequences a bank of DEPTH Registro_Paralelo instances used as a small audio sample buffer at the 44 kHz sample rate. In record mode it turns ADC sample strobes into one-hot register enables at successive indices. In play mode it walks a read index across the captured entries toward the DAC with a valid/ready handshake. It contains no sample datapath: the register bank and the output mux are external and driven by en_reg and rd_idx.

Parameters:
DEPTH, 8, number of registers in the bank (2..16)
IDX_W, 3, index width; DEPTH <= 2^IDX_W

Ports:
clk44kHz  input  1  sample clock; the only clock
reset  input  1  asynchronous, active-low (asserted at 0)
start_rec  input  1  one-cycle request to begin recording from index 0
start_play  input  1  one-cycle request to begin playback from index 0
stop  input  1  one-cycle request to abort the current record or play
loop  input  1  1 = playback wraps to index 0 after the last entry; 0 = stop after the last entry
sample_valid  input  1  ADC strobe; the sample is present on the bank's datoIn this cycle
dac_ready  input  1  DAC accepts the current output sample
en_reg  output  DEPTH  one-hot enable to the bank registers (the enable of each Registro_Paralelo)
wr_idx  output  IDX_W  next write index
rd_idx  output  IDX_W  current read index (select of the external output mux)
count  output  IDX_W+1  number of valid entries recorded
play_valid  output  1  rd_idx entry is presented to the DAC
full  output  1  count == DEPTH
busy  output  1  state is RECORD or PLAY
state  output  2  IDLE=0, RECORD=1, HOLD=2, PLAY=3

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. All state updates on the rising edge of clk44kHz; reset low clears everything immediately, with no clock edge required.
- Reset values: state=IDLE, wr_idx=0, rd_idx=0, count=0, play_valid=0, full=0, busy=0, en_reg=0.
- Command priority when several commands arrive in the same cycle: stop > start_rec > start_play. A command not valid in the current state is ignored.
- en_reg is combinational:
  - one-hot of wr_idx when state==RECORD && sample_valid;
  - otherwise all zeros.
  - The register therefore captures on the same edge that the controller advances, giving zero-cycle write latency.
- IDLE:
  - start_rec -> RECORD; wr_idx<=0, count<=0.
  - start_play -> PLAY only if count>0; sets rd_idx<=0 and play_valid<=1.
  - stop has no effect.
- RECORD, on sample_valid:
  - wr_idx<=wr_idx+1, count<=count+1.
  - If this write makes count==DEPTH -> HOLD. wr_idx does not advance past DEPTH-1 and never wraps.
  - stop -> HOLD with count retained. A sample_valid in the same cycle as stop is not written and en_reg stays 0.
  - start_rec in RECORD restarts the capture: wr_idx<=0, count<=0.
  - start_play is ignored.
- HOLD:
  - start_rec -> RECORD; clears wr_idx and count.
  - start_play -> PLAY if count>0; sets rd_idx<=0 and play_valid<=1.
  - stop is ignored.
- PLAY:
  - play_valid=1 while in PLAY. An entry advances only when play_valid && dac_ready.
  - Not on the last entry (rd_idx != count-1): rd_idx<=rd_idx+1.
  - On the last entry with loop=1: rd_idx<=0, stay in PLAY.
  - On the last entry with loop=0: -> HOLD, play_valid<=0, rd_idx holds count-1.
  - stop -> HOLD, play_valid<=0. Any handshake in that same cycle is discarded.
  - start_rec -> RECORD; play_valid<=0, count cleared.
- sample_valid outside RECORD and dac_ready outside PLAY are ignored.
- full and busy are decoded combinationally from count and state.
- Reset mid-record or mid-play: all state cleared and en_reg=0. Bank contents are not this block's concern, but count=0 makes them invalid.
- count=1 with loop=1: rd_idx stays at 0, and play_valid stays 1 on every dac_ready.

Test Plan:
- Reset low mid-RECORD with wr_idx=5 -> wr_idx=0, count=0, state=0, and en_reg=0 before the next edge.
- start_rec, then 8 sample_valid pulses (DEPTH=8) -> en_reg sequence 0x01, 0x02, 0x04, ... 0x80; after the 8th, count=8, full=1, state=HOLD. A 9th sample_valid -> en_reg=0.
- Record 3 samples, stop, start_play, loop=0, dac_ready held at 1 -> rd_idx 0, 1, 2 on consecutive cycles, then state=HOLD, play_valid=0, rd_idx=2.
- Same capture with loop=1 and dac_ready toggling 1,0,1,1 -> rd_idx 0, 1, 1, 2, then wraps to 0; state stays PLAY.
- start_play from reset (count=0) -> state stays IDLE, play_valid=0. stop and start_rec in the same cycle while in IDLE -> stop wins, state stays IDLE.
- In RECORD, sample_valid and stop in the same cycle -> en_reg=0, count unchanged, state=HOLD.

Source files
------------

// File: rtl/secuenciador_registros.sv
// Sequencer for a bank of DEPTH Registro_Paralelo audio sample registers at 44 kHz.
// Record mode issues one-hot write enables; play mode walks a read index toward the DAC.
module secuenciador_registros #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk44kHz,
  input  logic             reset,
  input  logic             start_rec,
  input  logic             start_play,
  input  logic             stop,
  input  logic             loop,
  input  logic             sample_valid,
  input  logic             dac_ready,
  output logic [DEPTH-1:0] en_reg,
  output logic [IDX_W-1:0] wr_idx,
  output logic [IDX_W-1:0] rd_idx,
  output logic [IDX_W:0]   count,
  output logic             play_valid,
  output logic             full,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    HOLD   = 2'd2,
    PLAY   = 2'd3
  } stateT;

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   ONE_C   = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  stateT            curState, nextState;
  logic [IDX_W-1:0] wrIdxNext, rdIdxNext;
  logic [IDX_W:0]   countNext;
  logic             playValidNext;
  logic             writeAccepted;
  logic             lastEntry;

  // A sample arriving together with stop is dropped, so it must not reach the bank.
  assign writeAccepted = (curState == RECORD) && sample_valid && !stop;
  assign lastEntry     = ({1'b0, rd_idx} == (count - ONE_C));

  always_comb begin
    en_reg = '0;
    for (int i = 0; i < DEPTH; i++) begin
      en_reg[i] = writeAccepted && (wr_idx == IDX_W'(i));
    end
  end

  assign full  = (count == DEPTH_C);
  assign busy  = (curState == RECORD) || (curState == PLAY);
  assign state = curState;

  always_ff @(posedge clk44kHz or negedge reset) begin
    if (!reset) begin
      curState   <= IDLE;
      wr_idx     <= '0;
      rd_idx     <= '0;
      count      <= '0;
      play_valid <= 1'b0;
    end else begin
      curState   <= nextState;
      wr_idx     <= wrIdxNext;
      rd_idx     <= rdIdxNext;
      count      <= countNext;
      play_valid <= playValidNext;
    end
  end

  // stop outranks every other command, even in states where it does nothing itself.
  always_comb begin
    nextState     = curState;
    wrIdxNext     = wr_idx;
    rdIdxNext     = rd_idx;
    countNext     = count;
    playValidNext = play_valid;
    case (curState)
      IDLE, HOLD: begin
        if (!stop) begin
          if (start_rec) begin
            nextState = RECORD;
            wrIdxNext = '0;
            countNext = '0;
          end else if (start_play && (count != '0)) begin
            nextState     = PLAY;
            rdIdxNext     = '0;
            playValidNext = 1'b1;
          end
        end
      end
      RECORD: begin
        if (stop) begin
          nextState = HOLD;
        end else if (start_rec) begin
          wrIdxNext = '0;
          countNext = '0;
        end else if (sample_valid) begin
          countNext = count + ONE_C;
          // The write that fills the bank leaves wr_idx parked on the last slot.
          if ((count + ONE_C) == DEPTH_C) begin
            nextState = HOLD;
          end else begin
            wrIdxNext = wr_idx + IDX_ONE;
          end
        end
      end
      PLAY: begin
        if (stop) begin
          nextState     = HOLD;
          playValidNext = 1'b0;
        end else if (start_rec) begin
          nextState     = RECORD;
          wrIdxNext     = '0;
          countNext     = '0;
          playValidNext = 1'b0;
        end else if (play_valid && dac_ready) begin
          if (!lastEntry) begin
            rdIdxNext = rd_idx + IDX_ONE;
          end else if (loop) begin
            rdIdxNext = '0;
          end else begin
            nextState     = HOLD;
            playValidNext = 1'b0;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule
